framebuffer_db: RTL and testbench

Double-buffered (ping-pong) LED framebuffer; successor to the single-bank framebuffer.
- Writer (frame loader) fills the back bank, then requests a commit.
- The LED shift-out engine reads the front bank.
- Banks swap only at the reader's frame boundary, so a displayed frame is never torn.
- Each bank carries its own frame-time value, presented alongside the front-bank data.

---
 rtl/fb_pkg.sv | 27 ++
 rtl/fb_bank.sv | 51 +++++
 rtl/framebuffer_db.sv | 109 ++++++++++
 tb/tb_framebuffer_db.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared sizing constants, control state type and the bring-up
// pattern helper for the double-buffered LED framebuffer.
package fb_pkg;

   localparam int c_ledboards          = 30;
   localparam int c_channels_per_board = 32;
   localparam int c_channels           = c_ledboards * c_channels_per_board;
   localparam int c_addr_w             = $clog2(c_channels);
   localparam int c_bpc                = 12;
   localparam int c_max_time           = 480;
   localparam int c_time_w             = $clog2(c_max_time);

   // Channel count one bit wider than an address, so the range check stays
   // correct even when c_channels is an exact power of two.
   localparam logic [c_addr_w:0] c_chan_count = (c_addr_w + 1)'(c_channels);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } fb_state_e;

   // Bring-up pattern: one lit channel (the first) per group of four.
   function automatic logic [c_bpc-1:0] init_value(input int unsigned n);
      return (n % 4 == 0) ? '1 : '0;
   endfunction

endpackage

// File: rtl/fb_bank.sv
// fb_bank: one simple dual-port RAM bank (one write port, one registered
// read port). When FB_INIT_PATTERN_EN is defined the contents power up with
// the bring-up pattern; otherwise they are undefined until written.
module fb_bank
   import fb_pkg::*;
#(
   parameter int DEPTH = c_channels,
   parameter int WIDTH = c_bpc,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   typedef logic [WIDTH-1:0] mem_t [DEPTH];

`ifdef FB_INIT_PATTERN_EN
   function automatic mem_t init_mem();
      mem_t m;
      for (int unsigned n = 0; n < DEPTH; n++) begin
         m[n] = (init_value(n) != '0) ? '1 : '0;
      end
      return m;
   endfunction

   mem_t mem_q = init_mem();
`else
   mem_t mem_q;
`endif

   logic [WIDTH-1:0] rdata_q;

   // Write port: no reset, contents survive a reset of the control logic.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read port; the caller masks out-of-range addresses.
   always_ff @(posedge clk_i) begin
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/framebuffer_db.sv
// framebuffer_db: ping-pong LED framebuffer. The writer fills the back bank
// and requests a commit; the swap waits for the reader's frame boundary so a
// displayed frame is never torn. Optional macro: FB_INIT_PATTERN_EN (bank
// bring-up pattern, handled inside fb_bank).
module framebuffer_db
   import fb_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_wen,
   input  logic [c_addr_w-1:0] i_waddr,
   input  logic [c_bpc-1:0]    i_wdata,
   input  logic [c_time_w-1:0] i_wtime,
   input  logic                i_commit,
   output logic                o_wbusy,
   input  logic                i_frame_start,
   input  logic [c_addr_w-1:0] i_raddr,
   output logic [c_bpc-1:0]    o_rdata,
   output logic [c_time_w-1:0] o_time,
   output logic                o_bank,
   output logic                o_swap
);

   fb_state_e           state_q, state_d;
   logic                bank_q;
   logic [c_time_w-1:0] time_q;
   logic [c_time_w-1:0] back_time_q;
   logic                swap_q;
   logic                rd_sel_q;   // front bank seen by the read in flight
   logic                rd_zero_q;  // read in flight was out of range (or reset)

   logic                swap_now;
   logic                wr_accept;
   logic                rd_in_range;
   logic [c_bpc-1:0]    bank_rdata [2];

   assign wr_accept   = i_wen && (state_q == ST_IDLE) && ({1'b0, i_waddr} < c_chan_count);
   assign rd_in_range = {1'b0, i_raddr} < c_chan_count;

   // Commit/swap control: a commit waits in PENDING for the frame boundary,
   // or swaps straight away when both arrive together in IDLE.
   always_comb begin
      state_d  = state_q;
      swap_now = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_commit && i_frame_start) begin
               swap_now = 1'b1;
            end else if (i_commit) begin
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (i_frame_start) begin
               swap_now = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers: bank select, frame times, swap pulse, read qualifiers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         bank_q      <= 1'b0;
         time_q      <= '0;
         back_time_q <= '0;
         swap_q      <= 1'b0;
         rd_sel_q    <= 1'b0;
         rd_zero_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         swap_q    <= swap_now;
         rd_sel_q  <= bank_q;
         rd_zero_q <= !rd_in_range;
         if (swap_now) begin
            bank_q <= ~bank_q;
            time_q <= back_time_q;
         end
         if (wr_accept) begin
            back_time_q <= i_wtime;
         end
      end
   end

   // Two identical banks; only the current back bank sees writes.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      fb_bank #(
         .DEPTH (c_channels),
         .WIDTH (c_bpc)
      ) u_bank (
         .clk_i   (i_clk),
         .we_i    (wr_accept && (bank_q != 1'(gi))),
         .waddr_i (i_waddr),
         .wdata_i (i_wdata),
         .raddr_i (i_raddr),
         .rdata_o (bank_rdata[gi])
      );
   end

   assign o_rdata = rd_zero_q ? '0 : bank_rdata[rd_sel_q];
   assign o_time  = time_q;
   assign o_bank  = bank_q;
   assign o_wbusy = (state_q == ST_PENDING);
   assign o_swap  = swap_q;

endmodule

// File: tb/tb_framebuffer_db.sv
// tb_framebuffer_db: scoreboard bench. The driver applies inputs on the
// falling edge, updates a behavioural model of the framebuffer and queues the
// expected outputs; the monitor compares them shortly after each rising edge.
module tb_framebuffer_db;
   import fb_pkg::*;

   logic                i_clk = 1'b0;
   logic                i_rst = 1'b1;
   logic                i_wen = 1'b0;
   logic [c_addr_w-1:0] i_waddr = '0;
   logic [c_bpc-1:0]    i_wdata = '0;
   logic [c_time_w-1:0] i_wtime = '0;
   logic                i_commit = 1'b0;
   logic                o_wbusy;
   logic                i_frame_start = 1'b0;
   logic [c_addr_w-1:0] i_raddr = '0;
   logic [c_bpc-1:0]    o_rdata;
   logic [c_time_w-1:0] o_time;
   logic                o_bank;
   logic                o_swap;

   framebuffer_db dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_wen         (i_wen),
      .i_waddr       (i_waddr),
      .i_wdata       (i_wdata),
      .i_wtime       (i_wtime),
      .i_commit      (i_commit),
      .o_wbusy       (o_wbusy),
      .i_frame_start (i_frame_start),
      .i_raddr       (i_raddr),
      .o_rdata       (o_rdata),
      .o_time        (o_time),
      .o_bank        (o_bank),
      .o_swap        (o_swap)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int rdata;
      bit rknown;
      int tm;
      int bank;
      int busy;
      int swap;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   txn    = 0;

   // Reference model state: two banks of channel values, plus frame bookkeeping.
   int   m_mem   [2][c_channels];
   bit   m_known [2][c_channels];
   int   m_front, m_ftime, m_btime;
   bit   m_pending;

   task automatic check(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (txn %0d)", name, act, want, txn);
      end
   endtask

   // Monitor: one expected record per rising edge.
   always @(posedge i_clk) begin
      #2;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         txn++;
         $display("txn %0d: rdata=%03h time=%0d bank=%0d busy=%0d swap=%0d",
                  txn, o_rdata, o_time, o_bank, o_wbusy, o_swap);
         if (e.rknown) check("rdata", int'(o_rdata), e.rdata);
         check("time",  int'(o_time),  e.tm);
         check("bank",  int'(o_bank),  e.bank);
         check("wbusy", int'(o_wbusy), e.busy);
         check("swap",  int'(o_swap),  e.swap);
      end
   end

   task automatic model_init();
      for (int b = 0; b < 2; b++) begin
         for (int n = 0; n < c_channels; n++) begin
`ifdef FB_INIT_PATTERN_EN
            m_mem[b][n]   = (n % 4 == 0) ? 'hFFF : 0;
            m_known[b][n] = 1'b1;
`else
            m_mem[b][n]   = 0;
            m_known[b][n] = 1'b0;
`endif
         end
      end
   endtask

   // One cycle with reset held: outputs must show the reset state.
   task automatic reset_cycle();
      exp_t e;
      @(negedge i_clk);
      i_rst = 1'b1; i_wen = 1'b0; i_commit = 1'b0; i_frame_start = 1'b0;
      m_front = 0; m_ftime = 0; m_btime = 0; m_pending = 1'b0;
      e = '{rdata: 0, rknown: 1'b1, tm: 0, bank: 0, busy: 0, swap: 0};
      exp_q.push_back(e);
   endtask

   // One functional cycle: drive inputs, advance the model, queue expectations.
   task automatic step(input bit wen, input int waddr, input int wdata, input int wtime,
                       input bit commit, input bit fs, input int raddr);
      exp_t e;
      bit   do_swap;
      int   new_btime;
      @(negedge i_clk);
      i_rst = 1'b0;
      i_wen = wen; i_waddr = c_addr_w'(waddr); i_wdata = c_bpc'(wdata);
      i_wtime = c_time_w'(wtime); i_commit = commit; i_frame_start = fs;
      i_raddr = c_addr_w'(raddr);

      if (raddr >= c_channels) begin
         e.rdata = 0; e.rknown = 1'b1;
      end else begin
         e.rdata = m_mem[m_front][raddr]; e.rknown = m_known[m_front][raddr];
      end

      new_btime = m_btime;
      if (wen && !m_pending && waddr < c_channels) begin
         m_mem[1 - m_front][waddr]   = wdata;
         m_known[1 - m_front][waddr] = 1'b1;
         new_btime = wtime;
      end

      do_swap = fs && (m_pending || commit);
      if (do_swap) begin
         m_ftime   = m_btime;
         m_front   = 1 - m_front;
         m_pending = 1'b0;
      end else if (commit) begin
         m_pending = 1'b1;
      end
      m_btime = new_btime;

      e.tm = m_ftime; e.bank = m_front; e.busy = int'(m_pending); e.swap = int'(do_swap);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int raddr);
      step(1'b0, 0, 0, 0, 1'b0, 1'b0, raddr);
   endtask

   initial begin
      model_init();
      m_front = 0; m_ftime = 0; m_btime = 0; m_pending = 1'b0;
      for (int i = 0; i < 3; i++) reset_cycle();

      // Reads straight after reset.
      for (int a = 0; a < 4; a++) idle(a);

      // Basic frame: write, commit, swap three cycles later, read back.
      step(1'b1, 5, 'hABC, 100, 1'b0, 1'b0, 0);
      step(1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 3; i++) idle(5);
      step(1'b0, 0, 0, 0, 1'b0, 1'b1, 5);
      idle(5);
      idle(5);

      // Writes while busy are dropped.
      step(1'b1, 7, 'h055, 50, 1'b0, 1'b0, 5);
      step(1'b0, 0, 0, 0, 1'b1, 1'b0, 5);
      step(1'b1, 7, 'h123, 60, 1'b0, 1'b0, 5);
      step(1'b0, 0, 0, 0, 1'b0, 1'b1, 7);
      idle(7);
      idle(7);

      // Commit and frame start together from IDLE, read across the swap edge.
      step(1'b1, 9, 'h321, 200, 1'b0, 1'b0, 9);
      step(1'b0, 0, 0, 0, 1'b1, 1'b1, 9);
      idle(9);
      idle(9);

      // Out-of-range write and read, then a swap shows the unchanged frame time.
      step(1'b1, c_channels, 'h777, 300, 1'b0, 1'b0, c_channels);
      step(1'b1, 1023, 'h777, 301, 1'b0, 1'b0, 1023);
      step(1'b0, 0, 0, 0, 1'b1, 1'b1, c_channels);
      idle(c_channels);

      // Reset while PENDING discards the commit.
      step(1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
      idle(0);
      reset_cycle();
      step(1'b0, 0, 0, 0, 1'b0, 1'b1, 0);
      idle(0);

      // Randomised traffic, mostly on a small address window so reads hit data.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            reset_cycle();
         end else begin
            int wa, ra;
            wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(c_channels, 1023))
                                             : int'($urandom_range(0, 15));
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(c_channels, 1023))
                                             : int'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), wa, int'($urandom_range(0, 4095)),
                 int'($urandom_range(0, c_max_time - 1)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0), ra);
         end
      end

      @(negedge i_clk);
      i_wen = 1'b0; i_commit = 1'b0; i_frame_start = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      check("drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
